uart_tx_buffered: RTL

// - Serialises the 8-bit host-protocol bytes produced by the event encoder onto the UART line to the PC.
// - Inputs are the encoder's dataStream/data_start pair; txd drives the board's RS-232 TX pin.
// - A small FIFO absorbs back-to-back events, for example a left scan followed immediately by a right scan.

---
 rtl/uart_tx_buffered.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter for the event encoder's host-protocol bytes.
// A small FIFO absorbs back-to-back events; frames are 8N1, or 8E1 when the
// macro UART_TX_PARITY_EN is defined (adds a PARITY state after DATA).
module uart_tx_buffered #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        data_in,
   input  logic              data_start,
   output logic              txd,
   output logic              busy,
   output logic              overflow,
   output logic [ADDR_W:0]   fifo_level
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state;
   logic              prev_start;
   logic [7:0]        prev_data;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [7:0]        shift_reg;
   logic [2:0]        bit_cnt;
   logic [CNT_W-1:0]  baud_cnt;
   logic              baud_last;
   logic              capture, pop, push, full;
`ifdef UART_TX_PARITY_EN
   logic              par_bit;
`endif

   // A held event is sent once; a changed byte under a held start is a new event.
   assign capture   = data_start & (~prev_start | (data_in != prev_data));
   assign full      = (fifo_level == FULL);
   assign pop       = (state == IDLE) && (fifo_level != '0);
   // A full FIFO still accepts the byte when the same cycle frees a slot.
   assign push      = capture & (~full | pop);
   assign baud_last = (baud_cnt == DIV_LAST);

   // Edge detector history for the encoder's level-style valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_start <= 1'b0;
         prev_data  <= 8'h00;
      end else begin
         prev_start <= data_start;
         prev_data  <= data_in;
      end
   end

   // FIFO storage, no reset needed: occupancy tracking gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (capture & ~push) overflow <= 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Transmit FSM; txd is registered so START begins on the pop edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         txd       <= 1'b1;
         busy      <= 1'b0;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         busy <= (state != IDLE) | (fifo_level != '0);
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (pop) begin
                  shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                  par_bit   <= ^mem[rd_ptr];
`endif
                  bit_cnt   <= 3'd0;
                  baud_cnt  <= '0;
                  txd       <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  txd      <= shift_reg[0];
                  state    <= DATA;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     txd   <= par_bit;
                     state <= PARITY;
`else
                     txd   <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     txd       <= shift_reg[1];
                  end
               end else baud_cnt <= baud_cnt + 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  txd      <= 1'b1;
                  state    <= STOP;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  txd      <= 1'b1;
                  state    <= IDLE;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
